// File: rtl/pair_splitter_with_flow_control_if.sv
// Handshake bundle for the pair splitter: one double-width upstream port
// and two single-width downstream branches.
interface pair_splitter_with_flow_control_if #(
    parameter int width = 8
);
    logic                 in_vld;
    logic                 in_rdy;
    logic [2*width-1:0]   in_data;
    logic                 a_vld;
    logic                 a_rdy;
    logic [width-1:0]     a_data;
    logic                 b_vld;
    logic                 b_rdy;
    logic [width-1:0]     b_data;

    modport master (
        output in_vld, in_data, a_rdy, b_rdy,
        input  in_rdy, a_vld, a_data, b_vld, b_data
    );

    modport slave (
        input  in_vld, in_data, a_rdy, b_rdy,
        output in_rdy, a_vld, a_data, b_vld, b_data
    );
endinterface

// File: rtl/pair_splitter_with_flow_control.sv
// Splits each upstream word into low/high halves, buffering each half in its
// own FIFO so the two branches drain independently.
module pair_splitter_with_flow_control #(
    parameter int width = 8,
    parameter int depth = 2
) (
    input logic                               clk,
    input logic                               rst,
    pair_splitter_with_flow_control_if.slave  bus
);
    localparam int ptr_w = (depth > 1) ? $clog2(depth) : 1;
    localparam int cnt_w = $clog2(depth + 1);

    typedef logic [ptr_w-1:0] ptr_t;
    typedef logic [cnt_w-1:0] cnt_t;

    logic [width-1:0] mem_a [depth];
    logic [width-1:0] mem_b [depth];

    ptr_t wr_a, rd_a, wr_b, rd_b;
    cnt_t cnt_a, cnt_b;

    logic push, pop_a, pop_b;

    // in_rdy and both vld flags depend on the counters only, so no
    // combinational path exists from any downstream ready to upstream.
    assign bus.in_rdy = (cnt_a != cnt_t'(depth)) && (cnt_b != cnt_t'(depth));
    assign bus.a_vld  = (cnt_a != '0);
    assign bus.b_vld  = (cnt_b != '0);
    assign bus.a_data = mem_a[rd_a];
    assign bus.b_data = mem_b[rd_b];

    assign push  = bus.in_vld & bus.in_rdy;
    assign pop_a = bus.a_vld & bus.a_rdy;
    assign pop_b = bus.b_vld & bus.b_rdy;

    // Storage carries no reset; stale entries are masked by the counters.
    always_ff @(posedge clk) begin
        if (!rst && push) begin
            mem_a[wr_a] <= bus.in_data[width-1:0];
            mem_b[wr_b] <= bus.in_data[2*width-1:width];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_a  <= '0;
            rd_a  <= '0;
            cnt_a <= '0;
            wr_b  <= '0;
            rd_b  <= '0;
            cnt_b <= '0;
        end else begin
            if (push) begin
                wr_a <= wr_a + ptr_t'(1);
                wr_b <= wr_b + ptr_t'(1);
            end
            if (pop_a) rd_a <= rd_a + ptr_t'(1);
            if (pop_b) rd_b <= rd_b + ptr_t'(1);

            case ({push, pop_a})
                2'b10:   cnt_a <= cnt_a + cnt_t'(1);
                2'b01:   cnt_a <= cnt_a - cnt_t'(1);
                default: cnt_a <= cnt_a;
            endcase

            case ({push, pop_b})
                2'b10:   cnt_b <= cnt_b + cnt_t'(1);
                2'b01:   cnt_b <= cnt_b - cnt_t'(1);
                default: cnt_b <= cnt_b;
            endcase
        end
    end
endmodule
